// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: datapath widths common to MAR, PC, IR and the
// W bus, plus the programming-controller state encoding.
package sap1_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_PROG = 2'd1,
    S_FULL = 2'd2
  } state_e;

endpackage

// File: rtl/sap1_prog_ctrl.sv
// Programming controller for the SAP-1 RAM: mode FSM plus the sequential
// fill-address counter.
//   clk, clr_n      clock, async active-low reset
//   prog            1 = programming mode requested
//   prog_valid      programming byte present
//   we, waddr       memory write strobe and address
//   prog_ready      byte accepted this cycle when prog_valid is high
//   prog_addr       address of the next accepted byte
//   prog_done       all words written this session
//   run             run mode (reads allowed)
module sap1_prog_ctrl
  import sap1_pkg::*;
#(
  parameter int ADDR_W = sap1_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              prog,
  input  logic              prog_valid,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic              prog_ready,
  output logic [ADDR_W-1:0] prog_addr,
  output logic              prog_done,
  output logic              run
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'((2**ADDR_W) - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              beat;

  // Dropping prog wins over a simultaneous handshake: no write that cycle.
  assign beat = (state_q == S_PROG) && prog && prog_valid;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= S_RUN;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      S_RUN: begin
        if (prog) begin
          state_d = S_PROG;
          addr_d  = '0;
        end
      end
      S_PROG: begin
        if (!prog) begin
          state_d = S_RUN;
          addr_d  = '0;
        end else if (prog_valid) begin
          // Counter wraps to 0 naturally as the last word is written.
          addr_d = addr_q + 1'b1;
          if (addr_q == LAST) state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (!prog) begin
          state_d = S_RUN;
          addr_d  = '0;
        end
      end
      default: begin
        state_d = S_RUN;
        addr_d  = '0;
      end
    endcase
  end

  always_comb begin
    we         = beat;
    waddr      = addr_q;
    prog_addr  = addr_q;
    prog_ready = (state_q == S_PROG);
    prog_done  = (state_q == S_FULL);
    run        = (state_q == S_RUN);
  end

endmodule

// File: rtl/sap1_ram16x8.sv
// SAP-1 16x8 program/data memory. Run mode: combinational read of the word
// addressed by the MAR onto the W bus when ce_n is low. Programming mode:
// valid/ready byte stream fills memory sequentially from address 0.
//   clk, clr_n            clock, async active-low reset (clears memory)
//   prog                  1 = programming mode
//   mar_q                 MAR address
//   ce_n                  active-low RAM-to-bus enable
//   prog_valid/prog_data  programming byte stream
//   prog_ready/prog_addr  acceptance and next write address
//   prog_done             memory filled this session
//   bus_out/bus_oe        read data toward the W bus (0 when not driving)
module sap1_ram16x8
  import sap1_pkg::*;
#(
  parameter int ADDR_W = sap1_pkg::ADDR_W,
  parameter int DATA_W = sap1_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              prog,
  input  logic [ADDR_W-1:0] mar_q,
  input  logic              ce_n,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic [ADDR_W-1:0] prog_addr,
  output logic              prog_done,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic                         we, run;
  logic [ADDR_W-1:0]            waddr;

  sap1_prog_ctrl #(.ADDR_W(ADDR_W)) u_ctrl (
    .clk        (clk),
    .clr_n      (clr_n),
    .prog       (prog),
    .prog_valid (prog_valid),
    .we         (we),
    .waddr      (waddr),
    .prog_ready (prog_ready),
    .prog_addr  (prog_addr),
    .prog_done  (prog_done),
    .run        (run)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      mem <= '0;
    end else if (we) begin
      mem[waddr] <= prog_data;
    end
  end

  // The FSM sits in S_RUN during reset, so clr_n gates the enable to keep
  // the bus released while reset is held.
  always_comb begin
    bus_oe  = run && !ce_n && clr_n;
    bus_out = bus_oe ? mem[mar_q] : '0;
  end

endmodule

// File: tb/tb_sap1_ram16x8.sv
// Directed bench for sap1_ram16x8. Stimulus pushes the expected output
// bundle into a queue; a monitor on the falling edge pops and compares.
module tb_sap1_ram16x8;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       prog;
  logic [3:0] mar_q;
  logic       ce_n;
  logic       prog_valid;
  logic [7:0] prog_data;
  logic       prog_ready;
  logic [3:0] prog_addr;
  logic       prog_done;
  logic [7:0] bus_out;
  logic       bus_oe;

  sap1_ram16x8 dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .prog       (prog),
    .mar_q      (mar_q),
    .ce_n       (ce_n),
    .prog_valid (prog_valid),
    .prog_data  (prog_data),
    .prog_ready (prog_ready),
    .prog_addr  (prog_addr),
    .prog_done  (prog_done),
    .bus_out    (bus_out),
    .bus_oe     (bus_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       ready;
    logic [3:0] addr;
    logic       done;
    logic       oe;
    logic [7:0] out;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic expect_out(input string name, input logic ready, input logic [3:0] addr,
                            input logic done, input logic oe, input logic [7:0] out);
    exp_t e;
    e.name = name; e.ready = ready; e.addr = addr; e.done = done; e.oe = oe; e.out = out;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every queued expectation against the outputs presented
  // mid-cycle, away from the active edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (prog_ready !== e.ready || prog_addr !== e.addr || prog_done !== e.done ||
          bus_oe !== e.oe || bus_out !== e.out) begin
        failures++;
        $display("FAIL %s: got ready=%b addr=%h done=%b oe=%b out=%h, want ready=%b addr=%h done=%b oe=%b out=%h",
                 e.name, prog_ready, prog_addr, prog_done, bus_oe, bus_out,
                 e.ready, e.addr, e.done, e.oe, e.out);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run-mode sweep of all 16 words against an expected image.
  task automatic sweep(input string name, input logic [7:0] img [16]);
    ce_n = 1'b0;
    for (int a = 0; a < 16; a++) begin
      mar_q = 4'(a);
      expect_out(name, 1'b0, 4'h0, 1'b0, 1'b1, img[a]);
      step();
    end
    ce_n = 1'b1;
  endtask

  logic [7:0] img [16];

  initial begin
    clr_n = 1'b0; prog = 1'b0; mar_q = 4'h3; ce_n = 1'b0;
    prog_valid = 1'b0; prog_data = 8'h00;
    step();
    expect_out("reset_state", 1'b0, 4'h0, 1'b0, 1'b0, 8'h00);
    step();
    clr_n = 1'b1;
    expect_out("run_empty_read", 1'b0, 4'h0, 1'b0, 1'b1, 8'h00);
    step();
    ce_n = 1'b1;
    expect_out("run_ce_off", 1'b0, 4'h0, 1'b0, 1'b0, 8'h00);
    step();

    // Full fill 10..1F, back-to-back beats, ce_n held low.
    prog = 1'b1; ce_n = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      prog_valid = 1'b1; prog_data = 8'h10 + 8'(i);
      expect_out("fill_beat", 1'b1, 4'(i), 1'b0, 1'b0, 8'h00);
      step();
    end
    prog_valid = 1'b0;
    expect_out("fill_done", 1'b0, 4'h0, 1'b1, 1'b0, 8'h00);
    step();
    prog_valid = 1'b1; prog_data = 8'hFF;  // 17th beat must be ignored
    step();
    prog_valid = 1'b0;
    expect_out("after_17th", 1'b0, 4'h0, 1'b1, 1'b0, 8'h00);
    step();

    prog = 1'b0;
    step();
    for (int a = 0; a < 16; a++) img[a] = 8'h10 + 8'(a);
    sweep("fill_sweep", img);

    // Gapped session then mid-session drop of prog at prog_addr=5.
    prog = 1'b1;
    step();
    prog_valid = 1'b1; prog_data = 8'hA5; step();
    prog_valid = 1'b0; prog_data = 8'h77; step();
    prog_valid = 1'b1; prog_data = 8'h3C; step();
    prog_valid = 1'b0;
    expect_out("gap_addr2", 1'b1, 4'h2, 1'b0, 1'b0, 8'h00);
    step();
    prog_valid = 1'b1;
    prog_data = 8'h55; step();
    prog_data = 8'h66; step();
    prog_data = 8'h77;
    expect_out("pre_drop_addr4", 1'b1, 4'h4, 1'b0, 1'b0, 8'h00);
    step();
    prog = 1'b0; prog_data = 8'hEE;  // valid still high: drop wins
    expect_out("drop_at_5", 1'b1, 4'h5, 1'b0, 1'b0, 8'h00);
    step();
    prog_valid = 1'b0;
    expect_out("dropped_run", 1'b0, 4'h0, 1'b0, 1'b0, 8'h00);
    step();
    img[0] = 8'hA5; img[1] = 8'h3C; img[2] = 8'h55; img[3] = 8'h66; img[4] = 8'h77;
    sweep("gap_sweep", img);

    // Re-enter, write one beat, then async reset between edges.
    prog = 1'b1;
    step();
    expect_out("reenter_addr0", 1'b1, 4'h0, 1'b0, 1'b0, 8'h00);
    prog_valid = 1'b1; prog_data = 8'h99;
    step();
    #2;
    clr_n = 1'b0;
    expect_out("async_reset", 1'b0, 4'h0, 1'b0, 1'b0, 8'h00);
    step();
    step();
    clr_n = 1'b1; prog = 1'b0; prog_valid = 1'b0;
    step();
    for (int a = 0; a < 16; a++) img[a] = 8'h00;
    sweep("post_reset_sweep", img);

    begin
      int budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        step();
        budget--;
      end
      if (exp_q.size() > 0) begin
        checks++;
        failures++;
        $display("FAIL drain: %0d expectations never compared, want 0", exp_q.size());
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
